// File: rtl/irq_nest_ctrl_pkg.sv
// rtl/irq_nest_ctrl_pkg.sv - shared cause indices, default edge mask and FSM encodings
package irq_nest_ctrl_pkg;

  // Number of sources the default cause map describes
  localparam int IRQ_NUM_SRC = 8;

  // Cause index constants; lower index means higher priority
  localparam int CAUSE_ILLEGAL_INSTR = 0;
  localparam int CAUSE_ECALL         = 1;
  localparam int CAUSE_BREAK         = 2;
  localparam int CAUSE_OVERFLOW      = 3;
  localparam int CAUSE_TIMER         = 4;
  localparam int CAUSE_UART          = 5;
  localparam int CAUSE_GPIO          = 6;
  localparam int CAUSE_BUTTON        = IRQ_NUM_SRC - 1;

  // Exceptions are level sources, external peripherals are edge sources
  localparam logic [IRQ_NUM_SRC-1:0] IRQ_DEFAULT_EDGE_MASK = 8'hF0;

  // Request FSM encodings
  typedef logic [0:0] irq_state_t;
  localparam irq_state_t ST_IDLE = 1'b0;
  localparam irq_state_t ST_REQ  = 1'b1;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - combinational lowest-index priority encoder
module irq_prio_enc
  import irq_nest_ctrl_pkg::*;
#(
  parameter int N = IRQ_NUM_SRC,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] index
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_nest_ctrl.sv
// rtl/irq_nest_ctrl.sv - nested interrupt controller with locked request/ack handshake
module irq_nest_ctrl
  import irq_nest_ctrl_pkg::*;
#(
  parameter int                 NUM_SRC    = IRQ_NUM_SRC,
  parameter logic [NUM_SRC-1:0] EDGE_MASK  = IRQ_DEFAULT_EDGE_MASK,
  parameter int                 NEST_DEPTH = 2,
  parameter int                 CAUSE_W    = $clog2(NUM_SRC),
  parameter int                 LVL_W      = $clog2(NEST_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  input  logic [NUM_SRC-1:0] int_mask,
  input  logic               status_ie,
  input  logic               int_ack,
  input  logic               int_ret,
  output logic               int_req,
  output logic [CAUSE_W-1:0] int_cause,
  output logic               exl,
  output logic [LVL_W-1:0]   nest_level,
  output logic [NUM_SRC-1:0] pending
);

  irq_state_t         state;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] clr_vec;
  logic [NUM_SRC-1:0] eligible;
  logic               win_valid;
  logic [CAUSE_W-1:0] win_idx;
  logic [CAUSE_W-1:0] tos;
  logic               win_ok;
  logic               do_push;
  logic               do_pop;
  logic [LVL_W-1:0]   lvl_nxt;
  logic [LVL_W-1:0]   push_idx;

  // Stack sized to the full counter range so nest_level indexes it directly
  logic [CAUSE_W-1:0] stack [2**LVL_W];

  assign set_vec  = (src & ~EDGE_MASK) | (src & ~src_q & EDGE_MASK);
  assign eligible = pending & int_mask;
  assign do_push  = (state == ST_REQ) && int_ack;
  assign do_pop   = int_ret && (nest_level != '0);
  assign tos      = stack[nest_level - LVL_W'(1)];

  irq_prio_enc #(
    .N (NUM_SRC),
    .W (CAUSE_W)
  ) u_prio_enc (
    .req   (eligible),
    .valid (win_valid),
    .index (win_idx)
  );

  // Winner may only be requested if it strictly outranks the handler in service
  always_comb begin
    win_ok = status_ie && win_valid && (nest_level < LVL_W'(NEST_DEPTH))
             && ((nest_level == '0) || (win_idx < tos));
  end

  // Ack clears exactly the pending bit of the cause that was accepted
  always_comb begin
    clr_vec = '0;
    if (do_push) begin
      clr_vec[int_cause] = 1'b1;
    end
  end

  // Pop happens before push, so a simultaneous ret+ack overwrites the top entry
  always_comb begin
    lvl_nxt  = nest_level;
    push_idx = nest_level;
    if (do_pop) begin
      lvl_nxt  = lvl_nxt - LVL_W'(1);
      push_idx = nest_level - LVL_W'(1);
    end
    if (do_push) begin
      lvl_nxt = lvl_nxt + LVL_W'(1);
    end
  end

  // Pending capture with set-over-clear priority and edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      src_q   <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | set_vec;
      src_q   <= src;
    end
  end

  // Nesting counter, in-service flag and priority stack
  always_ff @(posedge clk) begin
    if (rst) begin
      nest_level <= '0;
      exl        <= 1'b0;
      for (int i = 0; i < 2**LVL_W; i++) begin
        stack[i] <= '0;
      end
    end else begin
      nest_level <= lvl_nxt;
      exl        <= (lvl_nxt != '0);
      if (do_push) begin
        stack[push_idx] <= int_cause;
      end
    end
  end

  // Request FSM: cause is frozen in REQ until ack or mask-driven withdraw
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      int_req   <= 1'b0;
      int_cause <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_ok) begin
            int_cause <= win_idx;
            int_req   <= 1'b1;
            state     <= ST_REQ;
          end
        end
        default: begin
          if (int_ack || !int_mask[int_cause]) begin
            int_req <= 1'b0;
            state   <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
